// File: rtl/osd_dem_uart_16550_fifo.sv
// ============================================================================
// osd_dem_uart_16550_fifo
// 16550-compatible register front-end with TX/RX FIFOs and level interrupt.
// Rev 1.0
// ============================================================================
`default_nettype none

module osd_dem_uart_16550_fifo #(
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bus_req,
  input  logic [2:0] bus_addr,
  input  logic       bus_write,
  input  logic [7:0] bus_wdata,
  output logic       bus_ack,
  output logic [7:0] bus_rdata,
  output logic       irq,
  output logic       out_valid,
  output logic [7:0] out_char,
  input  logic       out_ready,
  input  logic       in_valid,
  input  logic [7:0] in_char,
  output logic       in_ready
);

  localparam int TXW = $clog2(TX_DEPTH);
  localparam int RXW = $clog2(RX_DEPTH);
  localparam logic [TXW:0] C_TX_FULL = (TXW+1)'(TX_DEPTH);
  localparam logic [RXW:0] C_RX_FULL = (RXW+1)'(RX_DEPTH);

  logic [7:0]     tx_mem [TX_DEPTH];
  logic [7:0]     rx_mem [RX_DEPTH];

  logic [TXW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [TXW:0]   tx_cnt_q, tx_cnt_d;
  logic [RXW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [RXW:0]   rx_cnt_q, rx_cnt_d;
  logic [3:0]     ier_q, ier_d;
  logic [7:0]     lcr_q, lcr_d;
  logic [4:0]     mcr_q, mcr_d;
  logic [7:0]     scr_q, scr_d;
  logic [7:0]     dll_q, dll_d;
  logic [7:0]     dlm_q, dlm_d;
  logic           thre_q, thre_d;
  logic           irq_q, irq_d;

  logic tx_empty, tx_full, rx_empty, rx_full, dlab;
  logic thr_wr, acc, tx_push, tx_pop, rx_push, rx_pop;
  logic rbr_rd, iir_rd, fcr_wr, tx_flush, rx_flush;
  logic [7:0] iir_val, lsr_val;

  assign tx_empty  = (tx_cnt_q == '0);
  assign tx_full   = (tx_cnt_q == C_TX_FULL);
  assign rx_empty  = (rx_cnt_q == '0);
  assign rx_full   = (rx_cnt_q == C_RX_FULL);
  assign dlab      = lcr_q[7];

  // A THR write into a full TX FIFO is the only access that is held off.
  assign thr_wr    = bus_req & bus_write & (bus_addr == 3'd0) & ~dlab;
  assign bus_ack   = bus_req & ~(thr_wr & tx_full);
  assign acc       = bus_req & bus_ack;

  assign tx_push   = thr_wr & ~tx_full;
  assign tx_pop    = out_valid & out_ready;
  assign rx_push   = in_valid & in_ready;
  assign rbr_rd    = acc & ~bus_write & (bus_addr == 3'd0) & ~dlab;
  assign rx_pop    = rbr_rd & ~rx_empty;
  assign iir_rd    = acc & ~bus_write & (bus_addr == 3'd2);
  assign fcr_wr    = acc & bus_write & (bus_addr == 3'd2);
  assign tx_flush  = fcr_wr & bus_wdata[2];
  assign rx_flush  = fcr_wr & bus_wdata[1];

  assign out_valid = ~tx_empty;
  assign out_char  = tx_mem[tx_rd_q];
  assign in_ready  = ~rx_full;
  assign irq       = irq_q;

  assign lsr_val   = {1'b0, tx_empty, tx_empty, 4'b0000, ~rx_empty};

  always_comb begin
    iir_val = 8'hC1;
    if (ier_q[0] & ~rx_empty)  iir_val = 8'hC4;
    else if (ier_q[1] & thre_q) iir_val = 8'hC2;
  end

  always_comb begin
    bus_rdata = 8'h00;
    case (bus_addr)
      3'd0: bus_rdata = dlab ? dll_q : (rx_empty ? 8'h00 : rx_mem[rx_rd_q]);
      3'd1: bus_rdata = dlab ? dlm_q : {4'b0000, ier_q};
      3'd2: bus_rdata = iir_val;
      3'd3: bus_rdata = lcr_q;
      3'd4: bus_rdata = {3'b000, mcr_q};
      3'd5: bus_rdata = lsr_val;
      3'd6: bus_rdata = 8'hB0;
      default: bus_rdata = scr_q;
    endcase
  end

  always_comb begin
    tx_wr_d  = tx_wr_q;
    tx_rd_d  = tx_rd_q;
    tx_cnt_d = tx_cnt_q;
    rx_wr_d  = rx_wr_q;
    rx_rd_d  = rx_rd_q;
    rx_cnt_d = rx_cnt_q;
    ier_d    = ier_q;
    lcr_d    = lcr_q;
    mcr_d    = mcr_q;
    scr_d    = scr_q;
    dll_d    = dll_q;
    dlm_d    = dlm_q;
    thre_d   = thre_q;

    if (tx_flush) begin
      tx_wr_d  = '0;
      tx_rd_d  = '0;
      tx_cnt_d = '0;
    end else begin
      if (tx_push) tx_wr_d = tx_wr_q + 1'b1;
      if (tx_pop)  tx_rd_d = tx_rd_q + 1'b1;
      if (tx_push & ~tx_pop)      tx_cnt_d = tx_cnt_q + 1'b1;
      else if (~tx_push & tx_pop) tx_cnt_d = tx_cnt_q - 1'b1;
    end

    if (rx_flush) begin
      rx_wr_d  = '0;
      rx_rd_d  = '0;
      rx_cnt_d = '0;
    end else begin
      if (rx_push) rx_wr_d = rx_wr_q + 1'b1;
      if (rx_pop)  rx_rd_d = rx_rd_q + 1'b1;
      if (rx_push & ~rx_pop)      rx_cnt_d = rx_cnt_q + 1'b1;
      else if (~rx_push & rx_pop) rx_cnt_d = rx_cnt_q - 1'b1;
    end

    if (acc & bus_write) begin
      case (bus_addr)
        3'd0: if (dlab) dll_d = bus_wdata;
        3'd1: if (dlab) dlm_d = bus_wdata; else ier_d = bus_wdata[3:0];
        3'd3: lcr_d = bus_wdata;
        3'd4: mcr_d = bus_wdata[4:0];
        3'd7: scr_d = bus_wdata;
        default: ;
      endcase
    end

    // Sets first, then clears, so a same-cycle clear always wins.
    if ((tx_pop & ~tx_push & (tx_cnt_q == 1)) | tx_flush) thre_d = 1'b1;
    if (acc & bus_write & (bus_addr == 3'd1) & ~dlab & bus_wdata[1] & ~ier_q[1] & tx_empty)
      thre_d = 1'b1;
    if (tx_push | (iir_rd & (iir_val == 8'hC2))) thre_d = 1'b0;

    irq_d = (ier_q[0] & ~rx_empty) | (ier_q[1] & thre_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_wr_q  <= '0;
      tx_rd_q  <= '0;
      tx_cnt_q <= '0;
      rx_wr_q  <= '0;
      rx_rd_q  <= '0;
      rx_cnt_q <= '0;
      ier_q    <= 4'h0;
      lcr_q    <= 8'h03;
      mcr_q    <= 5'h00;
      scr_q    <= 8'h00;
      dll_q    <= 8'h01;
      dlm_q    <= 8'h00;
      thre_q   <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      tx_wr_q  <= tx_wr_d;
      tx_rd_q  <= tx_rd_d;
      tx_cnt_q <= tx_cnt_d;
      rx_wr_q  <= rx_wr_d;
      rx_rd_q  <= rx_rd_d;
      rx_cnt_q <= rx_cnt_d;
      ier_q    <= ier_d;
      lcr_q    <= lcr_d;
      mcr_q    <= mcr_d;
      scr_q    <= scr_d;
      dll_q    <= dll_d;
      dlm_q    <= dlm_d;
      thre_q   <= thre_d;
      irq_q    <= irq_d;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_q] <= bus_wdata;
    if (rx_push) rx_mem[rx_wr_q] <= in_char;
  end

endmodule

`default_nettype wire

// File: tb/tb_osd_dem_uart_16550_fifo.sv
// ============================================================================
// tb_osd_dem_uart_16550_fifo
// Directed self-checking bench for the 16550 FIFO register front-end.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_osd_dem_uart_16550_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       bus_req = 1'b0;
  logic [2:0] bus_addr = 3'd0;
  logic       bus_write = 1'b0;
  logic [7:0] bus_wdata = 8'h00;
  logic       bus_ack;
  logic [7:0] bus_rdata;
  logic       irq;
  logic       out_valid;
  logic [7:0] out_char;
  logic       out_ready = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_char = 8'h00;
  logic       in_ready;

  int checks = 0;
  int errors = 0;

  osd_dem_uart_16550_fifo #(.TX_DEPTH(16), .RX_DEPTH(16)) dut (
    .clk(clk), .rst(rst),
    .bus_req(bus_req), .bus_addr(bus_addr), .bus_write(bus_write),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .irq(irq),
    .out_valid(out_valid), .out_char(out_char), .out_ready(out_ready),
    .in_valid(in_valid), .in_char(in_char), .in_ready(in_ready)
  );

  always #5 clk = ~clk;

  task automatic bus_xfer(input logic [2:0] a, input logic we, input logic [7:0] wd,
                          output logic [7:0] rd);
    bit ok;
    ok = 0;
    rd = 8'hxx;
    @(negedge clk);
    bus_req = 1'b1; bus_addr = a; bus_write = we; bus_wdata = wd;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (bus_ack === 1'b1) begin
        rd = bus_rdata;
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end else begin
      checks++; errors++;
      $display("FAIL bus_ack_timeout addr=%0d: bus_ack stayed %b, required 1", a, bus_ack);
    end
    bus_req = 1'b0; bus_write = 1'b0;
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [7:0] wd);
    logic [7:0] dummy;
    bus_xfer(a, 1'b1, wd, dummy);
  endtask

  task automatic bus_rd(input logic [2:0] a, output logic [7:0] rd);
    bus_xfer(a, 1'b0, 8'h00, rd);
  endtask

  task automatic rx_push(input logic [7:0] c);
    @(negedge clk);
    in_valid = 1'b1; in_char = c;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic test_reset;
    logic [7:0] d;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b, expected 0", irq); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b, expected 1", in_ready); end
    bus_rd(3'd5, d);
    checks++; if (d !== 8'h60) begin errors++; $display("FAIL reset_lsr: got %h, expected 60", d); end
    bus_rd(3'd2, d);
    checks++; if (d !== 8'hC1) begin errors++; $display("FAIL reset_iir: got %h, expected c1", d); end
    bus_rd(3'd3, d);
    checks++; if (d !== 8'h03) begin errors++; $display("FAIL reset_lcr: got %h, expected 03", d); end
    bus_rd(3'd6, d);
    checks++; if (d !== 8'hB0) begin errors++; $display("FAIL msr: got %h, expected b0", d); end
    bus_wr(3'd7, 8'hA5);
    bus_rd(3'd7, d);
    checks++; if (d !== 8'hA5) begin errors++; $display("FAIL scr: got %h, expected a5", d); end
    bus_wr(3'd5, 8'hFF);
    bus_rd(3'd5, d);
    checks++; if (d !== 8'h60) begin errors++; $display("FAIL lsr_write_ignored: got %h, expected 60", d); end
    bus_wr(3'd4, 8'hFF);
    bus_rd(3'd4, d);
    checks++; if (d !== 8'h1F) begin errors++; $display("FAIL mcr_mask: got %h, expected 1f", d); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq_late: got %b, expected 0", irq); end
  endtask

  task automatic test_tx_backpressure;
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) bus_wr(3'd0, 8'h41 + 8'(i));
    @(negedge clk);
    bus_req = 1'b1; bus_addr = 3'd0; bus_write = 1'b1; bus_wdata = 8'h51;
    #1;
    checks++; if (bus_ack !== 1'b0) begin errors++; $display("FAIL tx_full_stall: bus_ack=%b, expected 0", bus_ack); end
    checks++; if (out_valid !== 1'b1 || out_char !== 8'h41) begin
      errors++; $display("FAIL tx_head0: valid=%b char=%h, expected 1/41", out_valid, out_char);
    end
    out_ready = 1'b1;
    @(negedge clk); #1;
    checks++; if (bus_ack !== 1'b1) begin errors++; $display("FAIL tx_stall_release: bus_ack=%b, expected 1", bus_ack); end
    checks++; if (out_char !== 8'h42) begin errors++; $display("FAIL tx_head1: got %h, expected 42", out_char); end
    @(posedge clk); #1;
    bus_req = 1'b0; bus_write = 1'b0;
    for (int k = 8'h43; k <= 8'h51; k++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || out_char !== 8'(k)) begin
        errors++; $display("FAIL tx_order: valid=%b char=%h, expected 1/%h", out_valid, out_char, 8'(k));
      end
    end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL tx_drained: out_valid=%b, expected 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_tx_flush;
    logic [7:0] d;
    bus_wr(3'd0, 8'h11);
    bus_wr(3'd0, 8'h22);
    checks++; if (out_valid !== 1'b1 || out_char !== 8'h11) begin
      errors++; $display("FAIL tx_flush_pre: valid=%b char=%h, expected 1/11", out_valid, out_char);
    end
    bus_rd(3'd5, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL lsr_tx_busy: got %h, expected 00", d); end
    bus_wr(3'd2, 8'h04);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL tx_flush: out_valid=%b, expected 0", out_valid); end
    bus_rd(3'd5, d);
    checks++; if (d !== 8'h60) begin errors++; $display("FAIL lsr_after_flush: got %h, expected 60", d); end
  endtask

  task automatic test_rx_basic;
    logic [7:0] d;
    rx_push(8'h55);
    rx_push(8'hAA);
    bus_rd(3'd5, d);
    checks++; if (d !== 8'h61) begin errors++; $display("FAIL rx_lsr_dr: got %h, expected 61", d); end
    bus_rd(3'd0, d);
    checks++; if (d !== 8'h55) begin errors++; $display("FAIL rbr_first: got %h, expected 55", d); end
    bus_rd(3'd0, d);
    checks++; if (d !== 8'hAA) begin errors++; $display("FAIL rbr_second: got %h, expected aa", d); end
    bus_rd(3'd0, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL rbr_empty: got %h, expected 00", d); end
    bus_rd(3'd5, d);
    checks++; if (d !== 8'h60) begin errors++; $display("FAIL rx_lsr_empty: got %h, expected 60", d); end
  endtask

  task automatic test_rx_full;
    logic [7:0] d;
    for (int i = 0; i < 16; i++) rx_push(8'h80 + 8'(i));
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rx_full: in_ready=%b, expected 0", in_ready); end
    bus_rd(3'd0, d);
    checks++; if (d !== 8'h80) begin errors++; $display("FAIL rx_full_head: got %h, expected 80", d); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rx_room: in_ready=%b, expected 1", in_ready); end
    bus_wr(3'd2, 8'h02);
    bus_rd(3'd5, d);
    checks++; if (d !== 8'h60) begin errors++; $display("FAIL rx_flush: lsr=%h, expected 60", d); end
  endtask

  task automatic test_irq;
    logic [7:0] d;
    bus_wr(3'd1, 8'h03);
    rx_push(8'h31);
    bus_rd(3'd2, d);
    checks++; if (d !== 8'hC4) begin errors++; $display("FAIL iir_rx: got %h, expected c4", d); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_rx: got %b, expected 1", irq); end
    bus_rd(3'd0, d);
    checks++; if (d !== 8'h31) begin errors++; $display("FAIL irq_rbr: got %h, expected 31", d); end
    bus_rd(3'd2, d);
    checks++; if (d !== 8'hC2) begin errors++; $display("FAIL iir_thre: got %h, expected c2", d); end
    bus_rd(3'd2, d);
    checks++; if (d !== 8'hC1) begin errors++; $display("FAIL iir_cleared: got %h, expected c1", d); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_cleared: got %b, expected 0", irq); end
  endtask

  task automatic test_dlab;
    logic [7:0] d;
    bus_wr(3'd3, 8'h83);
    bus_wr(3'd0, 8'h0C);
    bus_wr(3'd1, 8'h00);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL dll_no_tx: out_valid=%b, expected 0", out_valid); end
    bus_rd(3'd0, d);
    checks++; if (d !== 8'h0C) begin errors++; $display("FAIL dll: got %h, expected 0c", d); end
    bus_rd(3'd1, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL dlm: got %h, expected 00", d); end
    bus_rd(3'd3, d);
    checks++; if (d !== 8'h83) begin errors++; $display("FAIL lcr_dlab: got %h, expected 83", d); end
    bus_wr(3'd3, 8'h03);
    bus_rd(3'd1, d);
    checks++; if (d !== 8'h03) begin errors++; $display("FAIL ier_back: got %h, expected 03", d); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] d;
    bus_wr(3'd0, 8'h77);
    bus_wr(3'd7, 8'h5A);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_tx: out_valid=%b, expected 0", out_valid); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mid_reset_irq: got %b, expected 0", irq); end
    @(negedge clk);
    rst = 1'b1;
    bus_rd(3'd7, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL mid_reset_scr: got %h, expected 00", d); end
    bus_rd(3'd1, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL mid_reset_ier: got %h, expected 00", d); end
    bus_wr(3'd3, 8'h83);
    bus_rd(3'd0, d);
    checks++; if (d !== 8'h01) begin errors++; $display("FAIL mid_reset_dll: got %h, expected 01", d); end
    bus_wr(3'd3, 8'h03);
  endtask

  initial begin
    test_reset;
    test_tx_backpressure;
    test_tx_flush;
    test_rx_basic;
    test_rx_full;
    test_irq;
    test_dlab;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/osd_dem_uart_16550_fifo.md
Name: osd_dem_uart_16550_fifo

Overview:
Buffered, parametrised 16550-compatible register front-end for the OSD UART device emulation module.
- TX path: CPU bus writes to THR go into a TX FIFO that drains to the debug side over a valid/ready character stream.
- RX path: debug-side characters go into an RX FIFO that the CPU reads through RBR.
- Full register file: IER/IIR/FCR/LCR/MCR/LSR/MSR/SCR and DLAB divisor latches.
- Drives a level interrupt, so 16550 drivers can run interrupt-driven rather than polled.

Parameters:
TX_DEPTH, 16, TX FIFO entries; power of two, 2..256.
RX_DEPTH, 16, RX FIFO entries; power of two, 2..256.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous assert, active-low (0 = reset); synchronously released by the integrator
bus_req  in  1  bus access request
bus_addr  in  3  register offset
bus_write  in  1  1 = write, 0 = read
bus_wdata  in  8  write data
bus_ack  out  1  access completes this cycle (combinational)
bus_rdata  out  8  read data (combinational, valid when bus_ack)
irq  out  1  level interrupt to CPU
out_valid  out  1  TX FIFO head valid
out_char  out  8  TX FIFO head
out_ready  in  1  debug side accepts out_char
in_valid  in  1  debug side offers in_char
in_char  in  8  RX character
in_ready  out  1  RX FIFO not full

Behaviour:
- Reset state:
  - Both FIFOs empty.
  - IER=0x00, LCR=0x03, MCR=0x00, SCR=0x00, DLL=0x01, DLM=0x00, thre_int=0.
  - Outputs: out_valid=0, in_ready=1, irq=0.
- Access timing:
  - An access is accepted when bus_req & bus_ack.
  - bus_ack=1 for every access except a THR write while the TX FIFO is full. That write stalls with bus_ack=0 until a slot frees.
  - Register updates and side effects take effect on the clk edge of acceptance.
- DLAB = LCR[7]. Offset map:
  - 0: DLAB ? DLL r/w : read RBR (pop RX) / write THR (push TX).
  - 1: DLAB ? DLM r/w : IER r/w. Bits [7:4] read 0. Only [1:0] are functional.
  - 2: read IIR / write FCR.
  - 3: LCR r/w.
  - 4: MCR r/w; bits [7:5] read 0.
  - 5: LSR, read-only; writes ignored.
  - 6: MSR, reads 0xB0 (CTS, DSR, DCD asserted); writes ignored.
  - 7: SCR r/w.
- Divisor latches are storage only; no baud timing exists.
- RBR read:
  - RX FIFO non-empty: returns the head and pops it.
  - RX FIFO empty: returns 0x00, no pop.
- THR write:
  - Pushes bus_wdata.
  - The character is presented on out_char with out_valid=1 from the cycle after acceptance.
  - A TX pop happens on out_valid & out_ready.
- RX push:
  - Happens on in_valid & in_ready, with in_ready = !rx_full.
  - LSR.DR is visible from the next cycle.
  - Overrun is impossible; LSR.OE is always 0.
- LSR bits:
  - [0] DR = !rx_empty
  - [5] THRE = tx_empty
  - [6] TEMT = tx_empty
  - all other bits 0
- FCR write:
  - bit1=1 flushes the RX FIFO.
  - bit2=1 flushes the TX FIFO.
  - Other bits are ignored; FIFOs are always enabled.
  - A flush wins over a same-cycle push or pop to that FIFO.
- thre_int flag:
  - Set when a TX pop leaves the FIFO empty.
  - Set when IER[1] goes 0->1 while the TX FIFO is empty.
  - Set by a TX flush.
  - Cleared by a THR write, or by an IIR read that returns 0xC2.
  - Clear has priority over set in the same cycle.
- IIR priority (bits [7:6]=11 always):
  - 0xC4 if IER[0] & DR.
  - else 0xC2 if IER[1] & thre_int.
  - else 0xC1.
- irq = (IER[0] & DR) | (IER[1] & thre_int). Registered, so it updates one cycle after the cause.
- Simultaneous events:
  - TX push and pop in the same cycle: count unchanged.
  - RX push and RBR pop in the same cycle: count unchanged. A push into an empty FIFO is not readable in the same cycle.
- FIFO pointers: log2(DEPTH)-bit pointers that wrap modulo DEPTH, plus a (log2(DEPTH)+1)-bit count.
- Reset mid-operation: assertion clears all state immediately. A stalled THR write is discarded.

Test Plan:
- Reset, then read offset 5 -> 0x60; offset 2 -> 0xC1; offset 3 -> 0x03; irq=0.
- Hold out_ready=0 and write 17 chars 0x41.. to THR with TX_DEPTH=16 -> first 16 acked; 17th bus_ack=0. Raise out_ready -> 17th acks one cycle after the first pop; chars emerge in order 0x41..0x51.
- Push 0x55, 0xAA via in_valid -> LSR=0x61; RBR reads 0x55 then 0xAA; a third read returns 0x00 and LSR=0x60.
- Fill RX with RX_DEPTH chars -> in_ready=0. One RBR read -> in_ready=1 the next cycle.
- Write IER=0x03, push 0x31 -> IIR=0xC4 and irq=1. Read RBR -> IIR=0xC2 (TX empty); read IIR once -> next IIR read 0xC1 and irq=0.
- Set LCR=0x83, write offset 0=0x0C and offset 1=0x00 -> no out_valid; read back 0x0C/0x00. Set LCR=0x03 -> offset 1 reads the IER value.
